// File: rtl/pipeline_reg_stage.sv
// pipeline_reg_stage: valid/ready register slice with a one-entry skid buffer.
// Forward and backward paths are both registered.
module pipeline_reg_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    logic [DATA_W-1:0] r_out_data, r_skid_data;
    logic              r_out_valid, r_skid_valid, r_in_ready;
    logic              w_out_free, w_accept;
    assign w_out_free = !r_out_valid || out_ready;
    assign w_accept   = in_valid && r_in_ready;
    assign in_ready   = r_in_ready;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) r_out_data <= in_data;
            end
        end else if (w_accept) begin
            // output stalled: park the new word so upstream sees no combinational ready
            r_skid_data  <= in_data;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pipeline_reg_stage.sv
// tb_pipeline_reg_stage: scoreboard bench; model is a FIFO of accepted, undelivered words
// (capacity two: in_ready while fewer than two held, out_valid while any held).
module tb_pipeline_reg_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb[$];
    logic       acc = 1'b0;
    logic [7:0] acc_data = '0;

    pipeline_reg_stage #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare against the model before each edge, retire delivered words, note accepts.
    always @(negedge clk) begin
        acc = 1'b0;
        if (rst_n) begin
            chk("mon_in_ready", 32'(in_ready), 32'(sb.size() < 2));
            chk("mon_out_valid", 32'(out_valid), 32'(sb.size() > 0));
            if (out_valid && sb.size() > 0) begin
                chk("mon_out_data", 32'(out_data), 32'(sb[0]));
                if (out_ready) void'(sb.pop_front());
            end
            acc      = in_valid && (sb.size() < 2 || (out_valid && out_ready && sb.size() < 2));
            acc      = in_valid && in_ready;
            acc_data = in_data;
        end
    end

    always @(posedge clk) if (acc) sb.push_back(acc_data);

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] cnt;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        // single word
        step(1, 8'h55, 0);
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 1);
        chk("single_data", 32'(out_data), 32'h55);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        chk("single_hold_valid", 32'(out_valid), 1);
        chk("single_hold_data", 32'(out_data), 32'h55);
        step(0, 8'h00, 1);
        chk("single_drained", 32'(out_valid), 0);
        // streaming
        for (int i = 1; i <= 16; i++) begin
            step(1, 8'(i), 1);
            chk("stream_data", 32'(out_data), 32'(i));
            chk("stream_valid", 32'(out_valid), 1);
            chk("stream_in_ready", 32'(in_ready), 1);
        end
        step(0, 8'h00, 1);
        chk("stream_drained", 32'(out_valid), 0);
        // skid fill
        step(1, 8'hA1, 0);
        step(1, 8'hA2, 0);
        chk("skid_head", 32'(out_data), 32'hA1);
        chk("skid_in_ready", 32'(in_ready), 0);
        step(1, 8'hA3, 0);
        chk("skid_reject_head", 32'(out_data), 32'hA1);
        chk("skid_reject_ready", 32'(in_ready), 0);
        step(1, 8'hA3, 1);
        chk("skid_move_data", 32'(out_data), 32'hA2);
        chk("skid_ready_back", 32'(in_ready), 1);
        step(1, 8'hA3, 1);
        chk("skid_a3", 32'(out_data), 32'hA3);
        step(0, 8'h00, 1);
        chk("skid_drained", 32'(out_valid), 0);
        // random traffic
        cnt = 8'h00;
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), cnt, 1'($urandom_range(0, 1)));
            cnt++;
        end
        repeat (3) step(0, 8'h00, 1);
        chk("rand_all_delivered", 32'(sb.size()), 0);
        // reset with both entries full
        step(1, 8'hB1, 0);
        step(1, 8'hB2, 0);
        chk("pre_rst_in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        step(0, 8'h00, 1);
        rst_n = 1'b1;
        repeat (3) step(0, 8'h00, 1);
        chk("post_rst_empty", 32'(out_valid), 0);
        // idle input ignored
        for (int i = 0; i < 8; i++) begin
            step(0, 8'($urandom), 1'($urandom_range(0, 1)));
            chk("idle_valid", 32'(out_valid), 0);
            chk("idle_data", 32'(out_data), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
